// File: rtl/pc_unit.sv
// Program counter: increment / signed branch / absolute jump, JAL link capture.
// Optional return-address stack when PC_UNIT_RAS_EN is defined; all outputs registered state.
module pc_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCen,
  input  logic              branch,
  input  logic              jump,
  input  logic              link,
  input  logic              ret,
  input  logic [7:0]        disp,
  input  logic [ADDR_W-1:0] jtarget,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              conflict,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;

  assign pc_inc = pc + ADDR_W'(1);
  assign pc_br  = pc + {{(ADDR_W-8){disp[7]}}, disp};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      link_addr <= '0;
      conflict  <= 1'b0;
    end else if (PCen) begin
      if (jump)        pc <= jtarget;
      else if (branch) pc <= pc_br;
      else             pc <= pc_inc;
      if (jump && branch) conflict  <= 1'b1;
      if (jump && link)   link_addr <= pc_inc;
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [PW-1:0]     top_ptr;
  logic [PW-1:0]     nxt_ptr;
  logic [PW:0]       count;
  logic              ras_op;

  assign nxt_ptr = top_ptr + PW'(1);
  assign ras_op  = PCen && jump;

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (ras_op && link) begin
      if (ret) stack[top_ptr] <= pc_inc;
      else     stack[nxt_ptr] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_ptr       <= '0;
      count         <= '0;
      ras_underflow <= 1'b0;
    end else if (ras_op) begin
      if (link && !ret) begin
        top_ptr <= nxt_ptr;
        if (count != (PW+1)'(STACK_DEPTH)) count <= count + (PW+1)'(1);
      end else if (ret && !link) begin
        if (count == '0) begin
          ras_underflow <= 1'b1;
        end else begin
          top_ptr <= top_ptr - PW'(1);
          count   <= count - (PW+1)'(1);
        end
      end
    end
  end

  assign ras_empty = (count == '0);
  assign ras_full  = (count == (PW+1)'(STACK_DEPTH));
  assign ras_top   = ras_empty ? '0 : stack[top_ptr];
`else
  logic unused_ras;
  assign unused_ras    = ret | (STACK_DEPTH < 2);
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule
